alu_share_arbiter: RTL

//  Shares the single 32-bit ALU between two requesters (0 = main datapath

---
 rtl/alu_share_arbiter_if.sv | 34 +++
 rtl/alu_share_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester and ALU-side signal bundle for the shared ALU arbiter
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              req0;
  logic [CTRL_W-1:0] ctrl0;
  logic [WIDTH-1:0]  a0;
  logic [WIDTH-1:0]  b0;
  logic              req1;
  logic [CTRL_W-1:0] ctrl1;
  logic [WIDTH-1:0]  a1;
  logic [WIDTH-1:0]  b1;
  logic              done0;
  logic              done1;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              busy;
  logic [CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  modport slave (
    input  req0, ctrl0, a0, b0, req1, ctrl1, a1, b1, alu_result, alu_zero,
    output done0, done1, result, zero, busy, alu_control, alu_a, alu_b
  );

  modport master (
    output req0, ctrl0, a0, b0, req1, ctrl1, a1, b1, alu_result, alu_zero,
    input  done0, done1, result, zero, busy, alu_control, alu_a, alu_b
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input logic                clock,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              pick1;
  logic              done0_q;
  logic              done1_q;
  logic              zero_q;
  logic [WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CTRL_W-1:0] ctrl_q;

  // On a tie, requester 1 wins only if requester 0 was served last.
  always_comb pick1 = bus.req1 & (~bus.req0 | ~last_grant);

  // last_grant doubles as the owner of the op in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ctrl_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req0 | bus.req1) begin
            last_grant <= pick1;
            ctrl_q     <= pick1 ? bus.ctrl1 : bus.ctrl0;
            a_q        <= pick1 ? bus.a1 : bus.a0;
            b_q        <= pick1 ? bus.b1 : bus.b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          done0_q  <= ~last_grant;
          done1_q  <= last_grant;
          state    <= S_DONE;
        end
        S_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          ctrl_q  <= '0;
          a_q     <= '0;
          b_q     <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.alu_control = ctrl_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
endmodule
